// File: rtl/mul_nibble_seq.sv
// WIDTH x WIDTH unsigned multiplier built from one external registered 4x4 core.
// Nibble pairs are issued one per cycle; shifted partial products are summed in place.
module mul_nibble_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 busy,
  output logic [3:0]           nib_a,
  output logic [3:0]           nib_b,
  input  logic [7:0]           nib_p
);

  localparam int M  = WIDTH / 4;
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int SW = IW + 3;
  localparam logic [IW-1:0] ILAST = IW'(M - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [2*WIDTH-1:0]   acc_q, acc_d, pp;
  logic [IW-1:0]        i_q, j_q, i_d, j_d;
  logic [SW-1:0]        sh_q;
  logic                 pend_q;
  logic                 last;
  logic [3:0]           nxa, nxb;
  logic                 in_ready_q, out_valid_q, busy_q;
  logic [2*WIDTH-1:0]   out_product_q;
  logic [3:0]           nib_a_q, nib_b_q;

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;
  assign busy        = busy_q;
  assign nib_a       = nib_a_q;
  assign nib_b       = nib_b_q;

  // i walks A's nibbles fastest; j advances once i wraps.
  always_comb begin
    pp      = '0;
    pp[7:0] = nib_p;
    acc_d   = acc_q;
    if (pend_q && (state_q == RUN || state_q == DRAIN))
      acc_d = acc_q + (pp << sh_q);
    last = (i_q == ILAST) && (j_q == ILAST);
    i_d  = i_q + 1'b1;
    j_d  = j_q;
    if (i_q == ILAST) begin
      i_d = '0;
      j_d = j_q + 1'b1;
    end
    nxa = 4'(a_q >> {i_d, 2'b00});
    nxb = 4'(b_q >> {j_d, 2'b00});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      i_q           <= '0;
      j_q           <= '0;
      sh_q          <= '0;
      pend_q        <= 1'b0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      busy_q        <= 1'b0;
      nib_a_q       <= '0;
      nib_b_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            acc_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
            nib_a_q    <= in_a[3:0];
            nib_b_q    <= in_b[3:0];
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          // Product of the pair driven now appears on nib_p next cycle.
          acc_q  <= acc_d;
          sh_q   <= {({1'b0, i_q} + {1'b0, j_q}), 2'b00};
          pend_q <= 1'b1;
          i_q    <= i_d;
          j_q    <= j_d;
          if (last) begin
            nib_a_q <= '0;
            nib_b_q <= '0;
            state_q <= DRAIN;
          end else begin
            nib_a_q <= nxa;
            nib_b_q <= nxb;
          end
        end
        DRAIN: begin
          acc_q         <= acc_d;
          out_product_q <= acc_d;
          out_valid_q   <= 1'b1;
          pend_q        <= 1'b0;
          state_q       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
